// File: rtl/shift_unit_seq_if.sv
// Handshake and data bundle for the multi-cycle shift unit.
interface shift_unit_seq_if #(
    parameter int unsigned N = 8
);
    localparam int unsigned SW = $clog2(N);

    logic          start;
    logic [1:0]    op;
    logic [N-1:0]  a;
    logic [SW-1:0] shamt;
    logic          busy;
    logic          done;
    logic [N-1:0]  c;

    // Requester side: issues operations, observes status and result
    modport master (
        output start, op, a, shamt,
        input  busy, done, c
    );

    // Shift unit side
    modport slave (
        input  start, op, a, shamt,
        output busy, done, c
    );
endinterface

// File: rtl/shift_unit_seq.sv
// Multi-cycle shift unit: LUI/SLL/SRL/SRA, one bit position per clock,
// with a start/busy/done handshake and a held result register.
module shift_unit_seq #(
    parameter int unsigned N = 8
) (
    input logic           clk,
    input logic           rst,
    shift_unit_seq_if.slave bus
);
    localparam int unsigned SW = $clog2(N);
    localparam logic [SW-1:0] Half = SW'(N / 2);
    localparam logic [1:0] OpLui = 2'b00;
    localparam logic [1:0] OpSll = 2'b01;
    localparam logic [1:0] OpSrl = 2'b10;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  sreg_q, sreg_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [1:0]    op_q, op_d;
    logic [N-1:0]  c_q, c_d;
    logic          busy_q, done_q;
    logic [N-1:0]  shifted;
    logic [SW-1:0] k;

    // Next-state logic: capture in idle, one-bit shift per cycle, publish result on DONE entry
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        c_d     = c_q;

        unique case (op_q)
            OpLui, OpSll: shifted = {sreg_q[N-2:0], 1'b0};
            OpSrl:        shifted = {1'b0, sreg_q[N-1:1]};
            default:      shifted = {sreg_q[N-1], sreg_q[N-1:1]};
        endcase

        // LUI is a fixed half-width left shift; shamt is ignored for it
        k = (bus.op == OpLui) ? Half : bus.shamt;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    sreg_d = bus.a;
                    op_d   = bus.op;
                    cnt_d  = k;
                    if (k == '0) begin
                        state_d = StDone;
                        c_d     = bus.a;
                    end else begin
                        state_d = StShift;
                    end
                end
            end
            StShift: begin
                sreg_d = shifted;
                cnt_d  = cnt_q - SW'(1);
                if (cnt_q == SW'(1)) begin
                    state_d = StDone;
                    c_d     = shifted;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs; synchronous active-low reset overrides everything
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            sreg_q  <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            c_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            c_q     <= c_d;
            busy_q  <= (state_d != StIdle);
            done_q  <= (state_d == StDone);
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.c    = c_q;
endmodule
